// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline stage: writeback bundle register with valid/ready handshake,
// one-entry skid buffer, synchronous flush and a saturating stall counter.
module mem_wb_skid_reg #(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 4,
    parameter int unsigned SCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_reg_wen,
    input  logic [AW-1:0]  in_reg_waddr,
    input  logic [DW-1:0]  in_mem_rdata,
    input  logic [DW-1:0]  in_alu_result,
    input  logic           in_mem_to_reg,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_reg_wen,
    output logic [AW-1:0]  out_reg_waddr,
    output logic [DW-1:0]  out_mem_rdata,
    output logic [DW-1:0]  out_alu_result,
    output logic           out_mem_to_reg,
    output logic [DW-1:0]  out_wb_data,
    output logic [SCW-1:0] stall_cnt
);

    typedef struct packed {
        logic          reg_wen;
        logic [AW-1:0] reg_waddr;
        logic [DW-1:0] mem_rdata;
        logic [DW-1:0] alu_result;
        logic          mem_to_reg;
    } bundle_t;

    logic    main_valid;
    logic    skid_valid;
    bundle_t main_q;
    bundle_t skid_q;
    bundle_t in_b;
    logic    in_fire;
    logic    load_main;

    assign in_b = '{reg_wen:    in_reg_wen,
                    reg_waddr:  in_reg_waddr,
                    mem_rdata:  in_mem_rdata,
                    alu_result: in_alu_result,
                    mem_to_reg: in_mem_to_reg};

    // in_ready depends only on held state, so no combinational path from out_ready
    assign in_ready  = !skid_valid;
    assign in_fire   = in_valid && in_ready;
    assign load_main = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            stall_cnt  <= '0;
        end else begin
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (load_main) begin
                if (skid_valid) begin
                    // skid full implies in_ready=0, so no new bundle can arrive here
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= in_fire;
                    if (in_fire) begin
                        main_q <= in_b;
                    end
                end
            end else if (in_fire) begin
                skid_q     <= in_b;
                skid_valid <= 1'b1;
            end

            if (main_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + SCW'(1);
            end
        end
    end

    always_comb begin
        out_valid      = main_valid;
        out_reg_wen    = main_q.reg_wen && main_valid;
        out_reg_waddr  = main_q.reg_waddr;
        out_mem_rdata  = main_q.mem_rdata;
        out_alu_result = main_q.alu_result;
        out_mem_to_reg = main_q.mem_to_reg;
        out_wb_data    = main_q.mem_to_reg ? main_q.mem_rdata : main_q.alu_result;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM/WB pipeline stage: registers the writeback bundle (register write enable, address, memory read data, ALU result, mem-to-reg select) between the memory stage and the register file.
- Adds a valid/ready handshake with a one-entry skid buffer, so backpressure from writeback never drops data.
- Adds synchronous flush, valid-qualified write enable, a muxed writeback data output and a saturating stall counter.

Parameters:
- DW, 16, width of mem_rdata / alu_result / wb_data
- AW, 4, width of register write address
- SCW, 8, width of stall counter

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- in_reg_wen  in  1  register write enable
- in_reg_waddr  in  AW  register write address
- in_mem_rdata  in  DW  memory read data
- in_alu_result  in  DW  ALU result
- in_mem_to_reg  in  1  1 = write back memory data, 0 = ALU result
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_reg_wen  out  1  reg write enable, qualified: held reg_wen AND out_valid
- out_reg_waddr  out  AW  held address
- out_mem_rdata  out  DW  held memory data
- out_alu_result  out  DW  held ALU result
- out_mem_to_reg  out  1  held select
- out_wb_data  out  DW  out_mem_to_reg ? out_mem_rdata : out_alu_result (combinational from registers)
- stall_cnt  out  SCW  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at posedge):
  - Main and skid valid flags and all payload registers cleared to 0; stall_cnt = 0.
  - After reset: out_valid=0, out_reg_wen=0, out_wb_data=0, in_ready=1.
  - rst has priority over flush and all handshakes.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !skid_valid; it is registered-state derived and independent of out_ready (no combinational path).
- Latency: a bundle accepted at edge N appears on outputs after edge N when the main register is empty or firing; minimum latency 1 cycle.
- Update rules at posedge (no rst, no flush):
  - Main empty or out_fire, skid valid: main <= skid. Skid <= input if in_fire, else skid_valid <= 0. (in_fire cannot occur here, since in_ready=0 when skid is valid.)
  - Main empty or out_fire, skid empty: main <= input, main_valid <= in_fire.
  - Main valid and !out_ready, in_fire: skid <= input, skid_valid <= 1.
  - Main valid and !out_ready, no in_fire: hold.
- Ordering: FIFO order is preserved; maximum two bundles are held.
- Payload retention: payload registers load only on capture; they hold their values when valid is dropped. Only out_reg_wen is valid-qualified.
- Flush (flush=1 at posedge):
  - main_valid <= 0 and skid_valid <= 0.
  - A bundle presented with in_fire in the same cycle is discarded.
  - Payload contents are don't-care afterwards, but out_reg_wen must read 0.
  - in_ready = 1 the following cycle.
- stall_cnt:
  - Increments each posedge where out_valid & !out_ready.
  - Saturates at 2^SCW-1.
  - Cleared only by rst, not by flush.
- Simultaneous out_fire and in_fire with an empty skid: the new bundle replaces the main register, giving back-to-back throughput of 1 bundle per cycle.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with alu_result=0x1234, waddr=3, wen=1, mem_to_reg=0, out_ready=1.
  - Next cycle: out_valid=1, out_reg_wen=1, out_wb_data=0x1234, in_ready=1.
- Backpressure/skid: out_ready=0, push A (mem_rdata=0xAAAA, mem_to_reg=1), then B (0xBBBB).
  - After B: in_ready=0 and out_wb_data=0xAAAA.
  - Raise out_ready: A and B are delivered in order on consecutive cycles, then in_ready=1.
- Flush: with A in main and B in skid, assert flush 1 cycle along with in_valid for C.
  - Next cycle: out_valid=0, out_reg_wen=0, in_ready=1; C is never delivered.
- Invalid qualification: in_valid=0 with in_reg_wen=1 -> out_reg_wen stays 0.
- Stall counter: SCW=2, hold out_valid=1 with out_ready=0 for 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3; flush does not clear it, rst does.
- Reset mid-operation: rst asserted with both entries full -> next cycle out_valid=0, in_ready=1, stall_cnt=0, out_wb_data=0.
